// File: rtl/disp_syncgen_p.sv
// Parametrised display timing generator: h/v counters, look-ahead pixel fetch strobe,
// LEAD-delayed HS/VS/DE, sticky VBLANK and frame-aligned start/stop.
//   state    | meaning
//   ST_IDLE  | counters held at 0, RUNNING=0
//   ST_RUN   | counting, DISPON high
//   ST_DRAIN | counting until end of frame, DISPON low
module disp_syncgen_p #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int LEAD     = 2,
  parameter int CW       = 11
) (
  input  logic          DCLK,
  input  logic          DRST,
  input  logic          DISPON,
  input  logic          CLRVBLNK,
  output logic [CW-1:0] HCNT,
  output logic [CW-1:0] VCNT,
  output logic          RDEN,
  output logic          FRAME_START,
  output logic          VGA_HS,
  output logic          VGA_VS,
  output logic          VGA_DE,
  output logic          VBLANK,
  output logic          RUNNING
);

  localparam int HTOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VTOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST  = CW'(HTOTAL - 1);
  localparam logic [CW-1:0] V_LAST  = CW'(VTOTAL - 1);
  localparam logic [CW-1:0] H_ACT   = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT   = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_BEG  = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END  = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_BEG  = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END  = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW-1:0] VB_LINE = CW'(V_ACTIVE - 1);
  localparam logic [CW-1:0] ONE     = CW'(1);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic [LEAD-1:0] de_pipe_q, de_pipe_d, hs_pipe_q, hs_pipe_d, vs_pipe_q, vs_pipe_d;
  logic            vblank_q, vblank_d;
  logic            running, at_last, rden_raw, hs_raw, vs_raw, vblank_set;

  always_comb begin
    state_d    = state_q;
    hcnt_d     = '0;
    vcnt_d     = '0;
    running    = (state_q != ST_IDLE);
    at_last    = (hcnt_q == H_LAST) && (vcnt_q == V_LAST);
    rden_raw   = running && (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
    hs_raw     = running && (hcnt_q >= HS_BEG) && (hcnt_q < HS_END);
    vs_raw     = running && (vcnt_q >= VS_BEG) && (vcnt_q < VS_END);
    vblank_set = running && (hcnt_q == H_LAST) && (vcnt_q == VB_LINE);

    case (state_q)
      ST_IDLE:  if (DISPON) state_d = ST_RUN;
      ST_RUN:   if (!DISPON) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (DISPON)       state_d = ST_RUN;
        else if (at_last) state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase

    if (running) begin
      if (hcnt_q == H_LAST) begin
        hcnt_d = '0;
        vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + ONE;
      end else begin
        hcnt_d = hcnt_q + ONE;
        vcnt_d = vcnt_q;
      end
    end

    // set has priority over a simultaneous software clear
    vblank_d = vblank_set | (vblank_q & ~CLRVBLNK);

    de_pipe_d[0] = rden_raw;
    hs_pipe_d[0] = hs_raw;
    vs_pipe_d[0] = vs_raw;
    for (int i = 1; i < LEAD; i++) begin
      de_pipe_d[i] = de_pipe_q[i-1];
      hs_pipe_d[i] = hs_pipe_q[i-1];
      vs_pipe_d[i] = vs_pipe_q[i-1];
    end
  end

  always_ff @(posedge DCLK) begin
    if (DRST) begin
      state_q   <= ST_IDLE;
      hcnt_q    <= '0;
      vcnt_q    <= '0;
      vblank_q  <= 1'b0;
      de_pipe_q <= '0;
      hs_pipe_q <= '0;
      vs_pipe_q <= '0;
    end else begin
      state_q   <= state_d;
      hcnt_q    <= hcnt_d;
      vcnt_q    <= vcnt_d;
      vblank_q  <= vblank_d;
      de_pipe_q <= de_pipe_d;
      hs_pipe_q <= hs_pipe_d;
      vs_pipe_q <= vs_pipe_d;
    end
  end

  assign HCNT        = hcnt_q;
  assign VCNT        = vcnt_q;
  assign RDEN        = rden_raw;
  assign FRAME_START = running && (hcnt_q == '0) && (vcnt_q == '0);
  assign RUNNING     = running;
  assign VBLANK      = vblank_q;
  assign VGA_DE      = de_pipe_q[LEAD-1];
  assign VGA_HS      = hs_pipe_q[LEAD-1] ? HS_POL : ~HS_POL;
  assign VGA_VS      = vs_pipe_q[LEAD-1] ? VS_POL : ~VS_POL;

endmodule

// File: tb/tb_disp_syncgen_p.sv
// Scoreboard bench for disp_syncgen_p: three builds (LEAD 2/1/8) on a 16x8 timing,
// checked every cycle against a linear-position reference model.
module tb_disp_syncgen_p;

  localparam int HA = 8, HF = 2, HSY = 3, HB = 3;
  localparam int VA = 4, VF = 1, VSY = 2, VB = 1;
  localparam int HT = HA + HF + HSY + HB;
  localparam int VT = VA + VF + VSY + VB;
  localparam int FT = HT * VT;

  logic DCLK = 1'b0, DRST = 1'b1, DISPON = 1'b0, CLRVBLNK = 1'b0;
  always #5 DCLK = ~DCLK;

  logic [2:0][10:0] hcnt, vcnt;
  logic [2:0]       rden, fs, hs, vs, de, vb, run;

  disp_syncgen_p #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
                   .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
                   .HS_POL(1'b0), .VS_POL(1'b0), .LEAD(2), .CW(11)) u_l2 (
    .DCLK(DCLK), .DRST(DRST), .DISPON(DISPON), .CLRVBLNK(CLRVBLNK),
    .HCNT(hcnt[0]), .VCNT(vcnt[0]), .RDEN(rden[0]), .FRAME_START(fs[0]),
    .VGA_HS(hs[0]), .VGA_VS(vs[0]), .VGA_DE(de[0]), .VBLANK(vb[0]), .RUNNING(run[0]));

  disp_syncgen_p #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
                   .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
                   .HS_POL(1'b0), .VS_POL(1'b0), .LEAD(1), .CW(11)) u_l1 (
    .DCLK(DCLK), .DRST(DRST), .DISPON(DISPON), .CLRVBLNK(CLRVBLNK),
    .HCNT(hcnt[1]), .VCNT(vcnt[1]), .RDEN(rden[1]), .FRAME_START(fs[1]),
    .VGA_HS(hs[1]), .VGA_VS(vs[1]), .VGA_DE(de[1]), .VBLANK(vb[1]), .RUNNING(run[1]));

  disp_syncgen_p #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
                   .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
                   .HS_POL(1'b0), .VS_POL(1'b0), .LEAD(8), .CW(11)) u_l8 (
    .DCLK(DCLK), .DRST(DRST), .DISPON(DISPON), .CLRVBLNK(CLRVBLNK),
    .HCNT(hcnt[2]), .VCNT(vcnt[2]), .RDEN(rden[2]), .FRAME_START(fs[2]),
    .VGA_HS(hs[2]), .VGA_VS(vs[2]), .VGA_DE(de[2]), .VBLANK(vb[2]), .RUNNING(run[2]));

  typedef struct {
    int       h, v;
    bit       rden, fs, run, vb;
    bit [2:0] de, hs, vs;
  } exp_t;

  exp_t exp_q[$];
  int   leads [3] = '{2, 1, 8};
  int   n_cmp = 0, n_err = 0;
  bit   done = 1'b0;

  // reference model: position within the frame as one linear index, plus run/stop flags
  bit m_run = 1'b0, m_stop = 1'b0, m_vb = 1'b0;
  int m_pos = 0;
  bit rh [8], hh [8], vh [8];

  task automatic step(input bit rst, input bit dsp, input bit clr);
    exp_t e;
    int   h, v;
    bit   last;
    DRST = rst; DISPON = dsp; CLRVBLNK = clr;
    h = m_pos % HT;
    v = m_pos / HT;
    if (rst) begin
      m_run = 0; m_stop = 0; m_pos = 0; m_vb = 0;
      for (int i = 0; i < 8; i++) begin rh[i] = 0; hh[i] = 0; vh[i] = 0; end
    end else begin
      for (int i = 7; i > 0; i--) begin rh[i] = rh[i-1]; hh[i] = hh[i-1]; vh[i] = vh[i-1]; end
      rh[0] = m_run && h < HA && v < VA;
      hh[0] = m_run && h >= HA + HF && h < HA + HF + HSY;
      vh[0] = m_run && v >= VA + VF && v < VA + VF + VSY;
      if (m_run && m_pos == VA * HT - 1) m_vb = 1;
      else if (clr)                      m_vb = 0;
      if (!m_run) begin
        if (dsp) begin m_run = 1; m_stop = 0; end
        m_pos = 0;
      end else begin
        last  = (m_pos == FT - 1);
        m_pos = (m_pos + 1) % FT;
        if (!m_stop)   m_stop = !dsp;
        else if (dsp)  m_stop = 0;
        else if (last) begin m_run = 0; m_stop = 0; m_pos = 0; end
      end
    end
    e.h    = m_pos % HT;
    e.v    = m_pos / HT;
    e.rden = m_run && e.h < HA && e.v < VA;
    e.fs   = m_run && m_pos == 0;
    e.run  = m_run;
    e.vb   = m_vb;
    for (int k = 0; k < 3; k++) begin
      e.de[k] = rh[leads[k]-1];
      e.hs[k] = !hh[leads[k]-1];
      e.vs[k] = !vh[leads[k]-1];
    end
    exp_q.push_back(e);
    @(posedge DCLK);
    #2;
  endtask

  task automatic run_n(input int n, input bit dsp, input int clr_rate);
    for (int i = 0; i < n; i++)
      step(1'b0, dsp, clr_rate > 0 && $urandom_range(0, clr_rate - 1) == 0);
  endtask

  task automatic goto_pos(input int h, input int v, input bit dsp);
    int guard = 0;
    while (m_pos != v * HT + h && guard < 400) begin
      step(1'b0, dsp, 1'b0);
      guard++;
    end
    if (m_pos != v * HT + h) begin
      n_cmp++; n_err++;
      $display("FAIL goto_pos: position (%0d,%0d) not reached, at index %0d", h, v, m_pos);
    end
  endtask

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s[lead=%0d] t=%0t: got %0d expected %0d", name, leads[k], $time, act, expv);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge DCLK);
      #1;
      if (!done) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL scoreboard: no expected entry at t=%0t", $time);
        end else begin
          e = exp_q.pop_front();
          for (int k = 0; k < 3; k++) begin
            chk("HCNT",        k, 32'(hcnt[k]), 32'(e.h));
            chk("VCNT",        k, 32'(vcnt[k]), 32'(e.v));
            chk("RDEN",        k, 32'(rden[k]), 32'(e.rden));
            chk("FRAME_START", k, 32'(fs[k]),   32'(e.fs));
            chk("RUNNING",     k, 32'(run[k]),  32'(e.run));
            chk("VBLANK",      k, 32'(vb[k]),   32'(e.vb));
            chk("VGA_DE",      k, 32'(de[k]),   32'(e.de[k]));
            chk("VGA_HS",      k, 32'(hs[k]),   32'(e.hs[k]));
            chk("VGA_VS",      k, 32'(vs[k]),   32'(e.vs[k]));
          end
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int  guard;
    bit  dsp;
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    run_n(4, 1'b0, 0);
    // start, run two frames with random VBLANK clears
    run_n(2 * FT + 37, 1'b1, 16);
    // mid-frame reset with DISPON held high
    repeat (3) step(1'b1, 1'b1, 1'b0);
    run_n(3, 1'b0, 0);
    // VBLANK: clear, set/clear collision, later clear
    run_n(1, 1'b1, 0);
    goto_pos(0, 1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    goto_pos(HT - 1, VA - 1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    run_n(5, 1'b1, 0);
    step(1'b0, 1'b1, 1'b1);
    run_n(10, 1'b1, 0);
    // drop DISPON at (4,2): drain to end of frame then idle
    goto_pos(4, 2, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    guard = 0;
    while (m_run && guard < 2 * FT) begin step(1'b0, 1'b0, 1'b0); guard++; end
    run_n(12, 1'b0, 0);
    // drop at (4,2), re-assert at (3,6): no gap
    run_n(1, 1'b1, 0);
    goto_pos(4, 2, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    goto_pos(3, 6, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    run_n(FT + 20, 1'b1, 0);
    // randomized soak
    dsp = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) dsp = !dsp;
      step($urandom_range(0, 499) == 0, dsp, $urandom_range(0, 11) == 0);
    end
    done = 1'b1;
    @(posedge DCLK);
    #5;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
